// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions (poly 0x07, MSB-first, no reflection, no final XOR)
// and the arbiter state encoding.
package crc8_pkg;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      CRC  = 2'd2
   } state_e;

   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/crc8_engine.sv
// 8-bit CRC accumulator: clear reloads the init value, en folds in one byte.
module crc8_engine
   import crc8_pkg::*;
#(
   parameter logic [7:0] CRC_INIT = 8'h00
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       en,
   input  logic [7:0] data,
   output logic [7:0] crc
);

   logic [7:0] crc_d, crc_q;

   always_comb begin
      crc_d = crc_q;
      if (clear) begin
         crc_d = CRC_INIT;
      end else if (en) begin
         crc_d = crc8_step(crc_q, data);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         crc_q <= CRC_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/crc8_frame_arb.sv
// Frame-level round-robin arbiter: one requester owns the output per frame,
// payload passes through combinationally, then the CRC byte closes the frame.
module crc8_frame_arb
   import crc8_pkg::*;
#(
   parameter int         NUM_REQ  = 2,
   parameter logic [7:0] CRC_INIT = 8'h00,
   localparam int        SW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_REQ*8-1:0] s_data,
   input  logic [NUM_REQ-1:0]   s_valid,
   input  logic [NUM_REQ-1:0]   s_last,
   output logic [NUM_REQ-1:0]   s_ready,
   output logic [7:0]           m_data,
   output logic                 m_valid,
   output logic                 m_last,
   output logic                 m_is_crc,
   input  logic                 m_ready,
   output logic [SW-1:0]        m_src,
   output logic                 busy
);

   state_e        state_d, state_q;
   logic [SW-1:0] m_src_d, m_src_q;
   logic [SW-1:0] rr_d, rr_q;
   logic [SW-1:0] grant;
   logic          found;
   int            idx;
   logic [7:0]    sel_data;
   logic          sel_valid;
   logic          sel_last;
   logic          crc_clear;
   logic          crc_en;
   logic [7:0]    crc;

   assign sel_data  = s_data[8*int'(m_src_q) +: 8];
   assign sel_valid = s_valid[m_src_q];
   assign sel_last  = s_last[m_src_q];

   // First valid requester scanning upward from rr_q, wrapping at NUM_REQ.
   always_comb begin
      grant = rr_q;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rr_q) + i) % NUM_REQ;
         if (!found && s_valid[idx]) begin
            found = 1'b1;
            grant = SW'(idx);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      m_src_d   = m_src_q;
      rr_d      = rr_q;
      crc_clear = 1'b0;
      crc_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               m_src_d   = grant;
               crc_clear = 1'b1;
               state_d   = PASS;
            end
         end
         PASS: begin
            if (sel_valid && m_ready) begin
               crc_en = 1'b1;
               if (sel_last) state_d = CRC;
            end
         end
         CRC: begin
            if (m_ready) begin
               rr_d    = (m_src_q == SW'(NUM_REQ - 1)) ? '0 : m_src_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         m_src_q <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         m_src_q <= m_src_d;
         rr_q    <= rr_d;
      end
   end

   crc8_engine #(.CRC_INIT(CRC_INIT)) u_crc (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (crc_clear),
      .en      (crc_en),
      .data    (sel_data),
      .crc     (crc)
   );

   // Everything reads zero in IDLE, so an async reset clears the outputs at once.
   always_comb begin
      m_data   = 8'h00;
      m_valid  = 1'b0;
      m_last   = 1'b0;
      m_is_crc = 1'b0;
      s_ready  = '0;
      case (state_q)
         PASS: begin
            m_data           = sel_data;
            m_valid          = sel_valid;
            s_ready[m_src_q] = m_ready;
         end
         CRC: begin
            m_data   = crc;
            m_valid  = 1'b1;
            m_last   = 1'b1;
            m_is_crc = 1'b1;
         end
         default: ;
      endcase
   end

   assign m_src = m_src_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_crc8_frame_arb.sv
// Directed bench for crc8_frame_arb: source queues per requester, expected
// output beats in a scoreboard queue checked as the DUT emits them.
module tb_crc8_frame_arb;

   localparam int N = 2;

   typedef struct packed {
      logic [7:0] d;
      logic       c;
      logic       l;
      logic       s;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [N*8-1:0] s_data = '0;
   logic [N-1:0] s_valid = '0;
   logic [N-1:0] s_last = '0;
   logic [N-1:0] s_ready;
   logic [7:0]   m_data;
   logic         m_valid;
   logic         m_last;
   logic         m_is_crc;
   logic         m_ready = 1'b1;
   logic         m_src;
   logic         busy;

   exp_t       exp_q[$];
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [N-1:0] hold = '0;
   int         crc_cyc[$];
   int         n_assert = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         beat_cnt = 0;
   bit         bp_mode = 1'b0;
   int         crc_wait = 0;

   crc8_frame_arb #(.NUM_REQ(N), .CRC_INIT(8'h00)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_last   (m_last),
      .m_is_crc (m_is_crc),
      .m_ready  (m_ready),
      .m_src    (m_src),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic present();
      s_valid[0] = (q0.size() != 0) && !hold[0];
      s_data[7:0] = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
      s_last[0] = (q0.size() != 0) ? q0[0][8] : 1'b0;
      s_valid[1] = (q1.size() != 0) && !hold[1];
      s_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
      s_last[1] = (q1.size() != 0) ? q1[0][8] : 1'b0;
   endtask

   // Source and sink driver: consume accepted bytes, present the next ones.
   always begin
      logic a0, a1;
      @(posedge clk);
      a0 = s_valid[0] & s_ready[0];
      a1 = s_valid[1] & s_ready[1];
      #1;
      if (a0 && q0.size() != 0) void'(q0.pop_front());
      if (a1 && q1.size() != 0) void'(q1.pop_front());
      present();
      if (!bp_mode) begin
         m_ready = 1'b1;
         crc_wait = 0;
      end else if (m_valid && m_is_crc) begin
         if (crc_wait < 3) begin
            m_ready = 1'b0;
            crc_wait++;
         end else begin
            m_ready = 1'b1;
         end
      end else begin
         m_ready = ~m_ready;
         crc_wait = 0;
      end
   end

   // Scoreboard: every accepted output beat must match the head of exp_q.
   always @(negedge clk) begin
      if (reset_n && m_valid && m_is_crc && !m_ready && exp_q.size() != 0) begin
         chk("crc_hold_data", 32'(m_data), 32'(exp_q[0].d));
      end
      if (reset_n && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("m_data", 32'(m_data), 32'(e.d));
            chk("m_is_crc", 32'(m_is_crc), 32'(e.c));
            chk("m_last", 32'(m_last), 32'(e.l));
            chk("m_src", 32'(m_src), 32'(e.s));
         end
         if (m_is_crc) crc_cyc.push_back(cyc);
         beat_cnt++;
      end
   end

   task automatic src_push(input int r, input logic [7:0] b[$]);
      for (int i = 0; i < b.size(); i++) begin
         if (r == 0) q0.push_back({(i == b.size() - 1), b[i]});
         else        q1.push_back({(i == b.size() - 1), b[i]});
      end
   endtask

   task automatic exp_push(input logic s, input logic [7:0] b[$], input logic [7:0] crc);
      for (int i = 0; i < b.size(); i++) exp_q.push_back('{d: b[i], c: 1'b0, l: 1'b0, s: s});
      exp_q.push_back('{d: crc, c: 1'b1, l: 1'b1, s: s});
   endtask

   task automatic wait_drain(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0) break;
      end
      chk(tag, 32'(exp_q.size() + q0.size() + q1.size()), 32'd0);
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_beats(input string tag, input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (beat_cnt >= target) break;
      end
      chk(tag, 32'(beat_cnt >= target), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] one[$];
      logic [7:0] ascii[$];
      logic [7:0] f12[$];
      logic [7:0] fff[$];
      logic [7:0] zero[$];
      logic [7:0] rst5[$];
      int base;

      one = '{8'h01};
      f12 = '{8'h01, 8'h02};
      fff = '{8'hFF};
      zero = '{8'h00};
      rst5 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      for (int i = 0; i < 9; i++) ascii.push_back(8'h31 + 8'(i));

      // Reset state
      #3;
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_last", 32'(m_last), 0);
      chk("rst_m_is_crc", 32'(m_is_crc), 0);
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_m_src", 32'(m_src), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // Single one-byte frame on requester 0
      src_push(0, one);
      exp_push(1'b0, one, 8'h07);
      wait_drain("t1_drain", 50);

      // "123456789" on requester 1
      src_push(1, ascii);
      exp_push(1'b1, ascii, 8'hF4);
      wait_drain("t2_drain", 100);

      // Both valid: grants alternate 0,1,0,1, N+2 cycles each
      crc_cyc.delete();
      src_push(0, f12); src_push(0, fff);
      src_push(1, f12); src_push(1, fff);
      exp_push(1'b0, f12, 8'h1B);
      exp_push(1'b1, f12, 8'h1B);
      exp_push(1'b0, fff, 8'hF3);
      exp_push(1'b1, fff, 8'hF3);
      wait_drain("t3_drain", 100);
      chk("t3_frames", 32'(crc_cyc.size()), 4);
      if (crc_cyc.size() == 4) begin
         chk("t3_cyc_f2", 32'(crc_cyc[1] - crc_cyc[0]), 4);
         chk("t3_cyc_f3", 32'(crc_cyc[2] - crc_cyc[1]), 3);
         chk("t3_cyc_f4", 32'(crc_cyc[3] - crc_cyc[2]), 3);
      end

      // Backpressure on requester 0
      base = beat_cnt;
      bp_mode = 1'b1;
      src_push(0, ascii);
      exp_push(1'b0, ascii, 8'hF4);
      wait_drain("t4_drain", 200);
      bp_mode = 1'b0;
      chk("t4_beats", 32'(beat_cnt - base), 10);
      repeat (2) @(posedge clk);

      // Gapped source: requester 1 granted (rr at 1), requester 0 waiting
      base = beat_cnt;
      src_push(1, ascii);
      src_push(0, fff);
      exp_push(1'b1, ascii, 8'hF4);
      exp_push(1'b0, fff, 8'hF3);
      wait_beats("t5_reach4", base + 4, 100);
      hold[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t5_other_ready", 32'(s_ready[0]), 0);
         chk("t5_src", 32'(m_src), 1);
         chk("t5_gap_valid", 32'(m_valid), 0);
         chk("t5_busy", 32'(busy), 1);
      end
      hold[1] = 1'b0;
      wait_drain("t5_drain", 100);

      // Reset mid-PASS after 3 bytes on requester 1 (rr currently 1)
      base = beat_cnt;
      src_push(1, rst5);
      for (int i = 0; i < 3; i++) exp_q.push_back('{d: rst5[i], c: 1'b0, l: 1'b0, s: 1'b1});
      wait_beats("t6_reach3", base + 3, 100);
      #2;
      chk("t6_pre_busy", 32'(busy), 1);
      reset_n = 1'b0;
      q0.delete();
      q1.delete();
      #1;
      chk("t6_m_valid", 32'(m_valid), 0);
      chk("t6_m_data", 32'(m_data), 0);
      chk("t6_m_last", 32'(m_last), 0);
      chk("t6_m_is_crc", 32'(m_is_crc), 0);
      chk("t6_s_ready", 32'(s_ready), 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_m_src", 32'(m_src), 0);
      chk("t6_exp_empty", 32'(exp_q.size()), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      src_push(0, zero);
      src_push(1, zero);
      exp_push(1'b0, zero, 8'h00);
      exp_push(1'b1, zero, 8'h00);
      wait_drain("t6_drain", 50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
